// File: rtl/sdram_scheduler_if.sv
// Handshake and command-bus bundle between the SDRAM scheduler, the write/read
// engines and the SDRAM pin registers.
interface sdram_scheduler_if;
    logic        init_done;
    logic        wr_req;
    logic        rd_req;
    logic        wr_idle;
    logic        rd_idle;
    logic        wr_enable;
    logic        rd_enable;
    logic        auto_refresh;
    logic        refresh_overrun;
    logic [2:0]  wr_command;
    logic [11:0] wr_address;
    logic [1:0]  wr_bank;
    logic [2:0]  rd_command;
    logic [11:0] rd_address;
    logic [1:0]  rd_bank;
    logic [2:0]  sdram_command;
    logic [11:0] sdram_address;
    logic [1:0]  sdram_bank;

    modport slave (
        input  init_done, wr_req, rd_req, wr_idle, rd_idle,
        input  wr_command, wr_address, wr_bank,
        input  rd_command, rd_address, rd_bank,
        output wr_enable, rd_enable, auto_refresh, refresh_overrun,
        output sdram_command, sdram_address, sdram_bank
    );

    modport master (
        output init_done, wr_req, rd_req, wr_idle, rd_idle,
        output wr_command, wr_address, wr_bank,
        output rd_command, rd_address, rd_bank,
        input  wr_enable, rd_enable, auto_refresh, refresh_overrun,
        input  sdram_command, sdram_address, sdram_bank
    );
endinterface

// File: rtl/sdram_scheduler.sv
// SDRAM command-bus arbiter: shares the bus between the write and read engines
// and inserts the periodic PRECHARGE-ALL + AUTO REFRESH sequence.
module sdram_scheduler #(
    parameter int REFRESH_INTERVAL = 1560,
    parameter int T_RP             = 2,
    parameter int T_RFC            = 7
) (
    input  logic              clk,
    input  logic              rst,
    sdram_scheduler_if.slave  bus
);
    // {RAS_n, CAS_n, WE_n} encodings shared with the engines
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_AR  = 3'b001;

    localparam int RW    = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int T_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int WW    = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;

    localparam logic [RW-1:0] REFRESH_RELOAD = RW'(REFRESH_INTERVAL - 1);
    localparam logic [RW-1:0] REFRESH_ONE    = RW'(1);
    localparam logic [RW-1:0] REFRESH_ZERO   = RW'(0);
    localparam logic [WW-1:0] TRP_LOAD       = WW'(T_RP - 1);
    localparam logic [WW-1:0] TRFC_LOAD      = WW'(T_RFC - 1);
    localparam logic [WW-1:0] WAIT_ONE       = WW'(1);
    localparam logic [WW-1:0] WAIT_ZERO      = WW'(0);
    localparam logic [11:0]   ADDR_ALL_BANKS = 12'h400;
    localparam logic [1:0]    HOLD_MIN       = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_READ      = 3'd2,
        S_PRE_ALL   = 3'd3,
        S_TRP_WAIT  = 3'd4,
        S_REFRESH   = 3'd5,
        S_TRFC_WAIT = 3'd6
    } state_t;

    state_t          state_r;
    logic [RW-1:0]   refresh_cnt_r;
    logic            refresh_pending_r;
    logic            refresh_overrun_r;
    logic            last_grant_write_r;
    logic [1:0]      hold_cnt_r;
    logic [WW-1:0]   wait_cnt_r;
    logic            wr_enable_r;
    logic            rd_enable_r;
    logic [2:0]      cmd_r;
    logic [11:0]     addr_r;
    logic [1:0]      bank_r;

    logic            refresh_expire_s;
    logic            refresh_clear_s;
    logic            pick_write_s;
    logic            wr_release_s;
    logic            rd_release_s;
    logic [2:0]      sdram_command_s;
    logic [11:0]     sdram_address_s;
    logic [1:0]      sdram_bank_s;

    assign refresh_expire_s = bus.init_done && (refresh_cnt_r == REFRESH_ZERO);
    assign refresh_clear_s  = (state_r == S_REFRESH);
    // Alternate on contention; a lone request always wins
    assign pick_write_s     = bus.wr_req && (!bus.rd_req || !last_grant_write_r);
    assign wr_release_s     = bus.wr_idle && (refresh_pending_r || !bus.wr_req || bus.rd_req);
    assign rd_release_s     = bus.rd_idle && (refresh_pending_r || !bus.rd_req || bus.wr_req);

    // Refresh interval timer, pending flag and overrun pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt_r     <= REFRESH_RELOAD;
            refresh_pending_r <= 1'b0;
            refresh_overrun_r <= 1'b0;
        end else begin
            refresh_overrun_r <= 1'b0;
            if (!bus.init_done) begin
                refresh_cnt_r <= REFRESH_RELOAD;
            end else if (refresh_expire_s) begin
                refresh_cnt_r <= REFRESH_RELOAD;
            end else begin
                refresh_cnt_r <= refresh_cnt_r - REFRESH_ONE;
            end
            // A new expiry outranks the clear of the refresh being issued now
            if (refresh_expire_s) begin
                refresh_pending_r <= 1'b1;
                refresh_overrun_r <= refresh_pending_r && !refresh_clear_s;
            end else if (refresh_clear_s) begin
                refresh_pending_r <= 1'b0;
            end else begin
                refresh_pending_r <= refresh_pending_r;
            end
        end
    end

    // Ownership / refresh sequencing FSM with registered grants and command
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= S_IDLE;
            last_grant_write_r <= 1'b0;
            hold_cnt_r         <= 2'd0;
            wait_cnt_r         <= WAIT_ZERO;
            wr_enable_r        <= 1'b0;
            rd_enable_r        <= 1'b0;
            cmd_r              <= CMD_NOP;
            addr_r             <= 12'h000;
            bank_r             <= 2'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    cmd_r  <= CMD_NOP;
                    addr_r <= 12'h000;
                    bank_r <= 2'd0;
                    if (!bus.init_done) begin
                        state_r <= S_IDLE;
                    end else if (refresh_pending_r) begin
                        state_r <= S_PRE_ALL;
                        cmd_r   <= CMD_PRE;
                        addr_r  <= ADDR_ALL_BANKS;
                    end else if (pick_write_s) begin
                        state_r            <= S_WRITE;
                        wr_enable_r        <= 1'b1;
                        last_grant_write_r <= 1'b1;
                        hold_cnt_r         <= 2'd0;
                    end else if (bus.rd_req) begin
                        state_r            <= S_READ;
                        rd_enable_r        <= 1'b1;
                        last_grant_write_r <= 1'b0;
                        hold_cnt_r         <= 2'd0;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                // Minimum two-cycle hold lets the engine leave its idle state
                S_WRITE: begin
                    if (hold_cnt_r != HOLD_MIN) begin
                        hold_cnt_r <= hold_cnt_r + 2'd1;
                    end else if (wr_release_s) begin
                        state_r     <= S_IDLE;
                        wr_enable_r <= 1'b0;
                    end else begin
                        state_r <= S_WRITE;
                    end
                end
                S_READ: begin
                    if (hold_cnt_r != HOLD_MIN) begin
                        hold_cnt_r <= hold_cnt_r + 2'd1;
                    end else if (rd_release_s) begin
                        state_r     <= S_IDLE;
                        rd_enable_r <= 1'b0;
                    end else begin
                        state_r <= S_READ;
                    end
                end
                S_PRE_ALL: begin
                    state_r    <= S_TRP_WAIT;
                    cmd_r      <= CMD_NOP;
                    addr_r     <= 12'h000;
                    bank_r     <= 2'd0;
                    wait_cnt_r <= TRP_LOAD;
                end
                S_TRP_WAIT: begin
                    if (wait_cnt_r == WAIT_ZERO) begin
                        state_r <= S_REFRESH;
                        cmd_r   <= CMD_AR;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - WAIT_ONE;
                    end
                end
                S_REFRESH: begin
                    state_r    <= S_TRFC_WAIT;
                    cmd_r      <= CMD_NOP;
                    wait_cnt_r <= TRFC_LOAD;
                end
                S_TRFC_WAIT: begin
                    if (wait_cnt_r == WAIT_ZERO) begin
                        state_r <= S_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - WAIT_ONE;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    wr_enable_r <= 1'b0;
                    rd_enable_r <= 1'b0;
                    cmd_r       <= CMD_NOP;
                    addr_r      <= 12'h000;
                    bank_r      <= 2'd0;
                end
            endcase
        end
    end

    // Zero-latency bus mux keyed on the registered owner state
    always_comb begin
        sdram_command_s = cmd_r;
        sdram_address_s = addr_r;
        sdram_bank_s    = bank_r;
        case (state_r)
            S_WRITE: begin
                sdram_command_s = bus.wr_command;
                sdram_address_s = bus.wr_address;
                sdram_bank_s    = bus.wr_bank;
            end
            S_READ: begin
                sdram_command_s = bus.rd_command;
                sdram_address_s = bus.rd_address;
                sdram_bank_s    = bus.rd_bank;
            end
            default: begin
                sdram_command_s = cmd_r;
                sdram_address_s = addr_r;
                sdram_bank_s    = bank_r;
            end
        endcase
    end

    assign bus.wr_enable       = wr_enable_r;
    assign bus.rd_enable       = rd_enable_r;
    assign bus.auto_refresh    = refresh_pending_r;
    assign bus.refresh_overrun = refresh_overrun_r;
    assign bus.sdram_command   = sdram_command_s;
    assign bus.sdram_address   = sdram_address_s;
    assign bus.sdram_bank      = sdram_bank_s;

endmodule

// File: tb/tb_sdram_scheduler.sv
// Directed bench for sdram_scheduler with a short refresh interval; expected
// cycle positions are counted from the first clock edge after reset release.
module tb_sdram_scheduler;
    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] AR  = 3'b001;
    localparam logic [2:0] WRC = 3'b100;
    localparam logic [2:0] RDC = 3'b101;
    localparam logic [2:0] ACT = 3'b011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sdram_scheduler_if bus_if ();

    sdram_scheduler #(
        .REFRESH_INTERVAL (16),
        .T_RP             (2),
        .T_RFC            (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [11:0] exp_w;
        logic [11:0] exp_r;
        logic [2:0]  exp_cmd;
        int          ov_count;
        int          pre_count;
        int          ar_count;

        bus_if.init_done  = 1'b0;
        bus_if.wr_req     = 1'b1;
        bus_if.rd_req     = 1'b0;
        bus_if.wr_idle    = 1'b1;
        bus_if.rd_idle    = 1'b1;
        bus_if.wr_command = WRC;
        bus_if.wr_address = 12'h5A5;
        bus_if.wr_bank    = 2'd2;
        bus_if.rd_command = RDC;
        bus_if.rd_address = 12'h0F0;
        bus_if.rd_bank    = 2'd1;

        // Reset values
        reset_dut();
        check("rst_cmd", bus_if.sdram_command, NOP);
        check("rst_addr", bus_if.sdram_address, 12'h000);
        check("rst_bank", bus_if.sdram_bank, 2'd0);
        check("rst_wr_en", bus_if.wr_enable, 1'b0);
        check("rst_rd_en", bus_if.rd_enable, 1'b0);
        check("rst_auto_ref", bus_if.auto_refresh, 1'b0);
        check("rst_overrun", bus_if.refresh_overrun, 1'b0);

        // No grants or refresh before init_done
        repeat (20) tick();
        check("noinit_wr_en", bus_if.wr_enable, 1'b0);
        check("noinit_auto_ref", bus_if.auto_refresh, 1'b0);

        // Test 1: write grant and zero-latency pass-through
        bus_if.init_done = 1'b1;
        tick();
        check("t1_wr_en", bus_if.wr_enable, 1'b1);
        check("t1_rd_en", bus_if.rd_enable, 1'b0);
        check("t1_cmd", bus_if.sdram_command, WRC);
        check("t1_addr", bus_if.sdram_address, 12'h5A5);
        check("t1_bank", bus_if.sdram_bank, 2'd2);
        bus_if.wr_command = ACT;
        bus_if.wr_address = 12'h123;
        #1;
        check("t1_cmd_comb", bus_if.sdram_command, ACT);
        check("t1_addr_comb", bus_if.sdram_address, 12'h123);
        bus_if.wr_req = 1'b0;
        tick();
        check("t1_hold_c2", bus_if.wr_enable, 1'b1);
        tick();
        check("t1_hold_c3", bus_if.wr_enable, 1'b1);
        tick();
        check("t1_release", bus_if.wr_enable, 1'b0);
        check("t1_release_cmd", bus_if.sdram_command, NOP);

        // Test 2: alternating grants under continuous contention
        bus_if.wr_command = WRC;
        bus_if.wr_req = 1'b1;
        bus_if.rd_req = 1'b1;
        reset_dut();
        exp_w = 12'b111000001110;
        exp_r = 12'b000011100000;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_cmd = exp_w[11-i] ? WRC : (exp_r[11-i] ? RDC : NOP);
            check("t2_wr_en", bus_if.wr_enable, exp_w[11-i]);
            check("t2_rd_en", bus_if.rd_enable, exp_r[11-i]);
            check("t2_cmd", bus_if.sdram_command, exp_cmd);
        end

        // Test 3: refresh sequence on an idle bus
        bus_if.wr_req = 1'b0;
        bus_if.rd_req = 1'b0;
        reset_dut();
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("t3_pre_idle_cmd", bus_if.sdram_command, NOP);
            if (i == 15) check("t3_auto_ref_early", bus_if.auto_refresh, 1'b0);
        end
        check("t3_auto_ref", bus_if.auto_refresh, 1'b1);
        tick();
        check("t3_pre_cmd", bus_if.sdram_command, PRE);
        check("t3_pre_addr", bus_if.sdram_address, 12'h400);
        check("t3_pre_bank", bus_if.sdram_bank, 2'd0);
        tick();
        check("t3_trp1", bus_if.sdram_command, NOP);
        tick();
        check("t3_trp2", bus_if.sdram_command, NOP);
        tick();
        check("t3_ar_cmd", bus_if.sdram_command, AR);
        bus_if.wr_req = 1'b1;
        tick();
        check("t3_auto_ref_clr", bus_if.auto_refresh, 1'b0);
        check("t3_trfc_cmd", bus_if.sdram_command, NOP);
        for (int i = 22; i <= 28; i++) begin
            tick();
            check("t3_trfc_no_grant", bus_if.wr_enable, 1'b0);
        end
        tick();
        check("t3_grant_after_refresh", bus_if.wr_enable, 1'b1);

        // Test 4: refresh expiry during a busy write burst
        bus_if.wr_req  = 1'b1;
        bus_if.rd_req  = 1'b0;
        bus_if.wr_idle = 1'b1;
        reset_dut();
        tick();
        check("t4_wr_en", bus_if.wr_enable, 1'b1);
        bus_if.wr_idle = 1'b0;
        bus_if.rd_req  = 1'b1;
        for (int i = 2; i <= 20; i++) begin
            tick();
            check("t4_no_read", bus_if.rd_enable, 1'b0);
            if (i == 16) check("t4_auto_ref", bus_if.auto_refresh, 1'b1);
        end
        check("t4_wr_held", bus_if.wr_enable, 1'b1);
        bus_if.wr_idle = 1'b1;
        tick();
        check("t4_wr_release", bus_if.wr_enable, 1'b0);
        check("t4_rd_wait", bus_if.rd_enable, 1'b0);
        tick();
        check("t4_pre_first", bus_if.sdram_command, PRE);
        check("t4_rd_still_off", bus_if.rd_enable, 1'b0);

        // Test 5: overrun pulse while a write burst spans two intervals
        bus_if.wr_req  = 1'b1;
        bus_if.rd_req  = 1'b0;
        bus_if.wr_idle = 1'b1;
        reset_dut();
        tick();
        bus_if.wr_idle = 1'b0;
        ov_count = 0;
        for (int i = 2; i <= 34; i++) begin
            tick();
            if (bus_if.refresh_overrun) ov_count++;
            if (i == 32) check("t5_overrun_pulse", bus_if.refresh_overrun, 1'b1);
        end
        check("t5_overrun_once", ov_count, 1);
        bus_if.wr_idle = 1'b1;
        bus_if.wr_req  = 1'b0;
        pre_count = 0;
        ar_count  = 0;
        for (int i = 35; i <= 47; i++) begin
            tick();
            if (bus_if.sdram_command === PRE) pre_count++;
            if (bus_if.sdram_command === AR) ar_count++;
        end
        check("t5_one_pre", pre_count, 1);
        check("t5_one_ar", ar_count, 1);

        // Test 6: reset in the middle of tRFC
        bus_if.wr_req = 1'b0;
        bus_if.rd_req = 1'b0;
        reset_dut();
        repeat (22) tick();
        rst = 1'b1;
        tick();
        check("t6_cmd", bus_if.sdram_command, NOP);
        check("t6_wr_en", bus_if.wr_enable, 1'b0);
        check("t6_rd_en", bus_if.rd_enable, 1'b0);
        check("t6_auto_ref", bus_if.auto_refresh, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 9) check("t6_reload_f9", bus_if.auto_refresh, 1'b0);
            if (i == 15) check("t6_reload_f15", bus_if.auto_refresh, 1'b0);
        end
        check("t6_reload_f16", bus_if.auto_refresh, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Mutual exclusion of grants checked every cycle
    always @(negedge clk) begin
        if (!rst && bus_if.wr_enable && bus_if.rd_enable) begin
            checks++;
            errors++;
            $error("FAIL grant_overlap: observed wr=%0b rd=%0b expected not both", bus_if.wr_enable, bus_if.rd_enable);
        end
    end
endmodule
